// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and tracker state type
package mips_pkg;

    localparam int NB_REG_DEF = 5;

    // RegDst encodings
    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_RA  = 2'b10;
    localparam logic [1:0] REGDST_RSV = 2'b11;

    localparam int REG_RA = 31;

    // Tracker FSM state
    typedef logic [0:0] tracker_state_t;
    localparam tracker_state_t ST_RUN        = 1'b0;
    localparam tracker_state_t ST_LOAD_STALL = 1'b1;

endpackage

// File: rtl/pipe_dest_slot.sv
// rtl/pipe_dest_slot.sv - one pipeline slot holding {rd, RegWrite, MemRead}
//
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_halt (hold all state)
//   i_rd, i_RegWrite, i_MemRead  : next slot contents
//   o_rd, o_RegWrite, o_MemRead  : registered slot contents
module pipe_dest_slot #(
    parameter int NB_REG = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_halt,
    input  logic [NB_REG-1:0] i_rd,
    input  logic              i_RegWrite,
    input  logic              i_MemRead,
    output logic [NB_REG-1:0] o_rd,
    output logic              o_RegWrite,
    output logic              o_MemRead
);

    // Reset wins over halt so a frozen pipeline can still be cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rd       <= '0;
            o_RegWrite <= 1'b0;
            o_MemRead  <= 1'b0;
        end else if (!i_halt) begin
            o_rd       <= i_rd;
            o_RegWrite <= i_RegWrite;
            o_MemRead  <= i_MemRead;
        end
    end

endmodule

// File: rtl/writeback_tracker.sv
// rtl/writeback_tracker.sv - EX->M->WB destination tracking and load-use stall
//
// Configuration macro: WRITEBACK_TRACKER_LOAD_USE_EN (defined = build the
// load-use FSM and stall; undefined = o_stall tied 0, no FSM).
//
// Ports:
//   i_clk, i_rst_n (sync, active-low), i_halt (freeze)
//   EX inputs : i_valid_ex, i_rt/rd_from_EX, i_RegDst/RegWrite/MemRead_from_EX
//   ID inputs : i_rs_from_ID, i_rt_from_ID
//   M slot    : o_rd_from_M, o_RegWrite_from_M, o_MemRead_from_M
//   WB slot   : o_rd_from_WB, o_RegWrite_from_WB
//   o_stall   : combinational load-use stall request
module writeback_tracker
    import mips_pkg::*;
#(
    parameter int NB_REG     = NB_REG_DEF,
    parameter int NB_DST_SEL = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_halt,
    input  logic                  i_valid_ex,
    input  logic [NB_REG-1:0]     i_rt_from_EX,
    input  logic [NB_REG-1:0]     i_rd_from_EX,
    input  logic [NB_DST_SEL-1:0] i_RegDst_from_EX,
    input  logic                  i_RegWrite_from_EX,
    input  logic                  i_MemRead_from_EX,
    input  logic [NB_REG-1:0]     i_rs_from_ID,
    input  logic [NB_REG-1:0]     i_rt_from_ID,
    output logic [NB_REG-1:0]     o_rd_from_M,
    output logic                  o_RegWrite_from_M,
    output logic                  o_MemRead_from_M,
    output logic [NB_REG-1:0]     o_rd_from_WB,
    output logic                  o_RegWrite_from_WB,
    output logic                  o_stall
);

    logic [NB_REG-1:0] dest;
    logic              mask;
    logic              wr_ex;
    logic              ld_ex;
    logic [NB_REG-1:0] rd_ex;
    logic              m_MemRead_unused_wb;

    // Reserved RegDst resolves to r0, which the dest != 0 term then suppresses.
    always_comb begin
        dest = '0;
        case (i_RegDst_from_EX)
            NB_DST_SEL'(REGDST_RT): dest = i_rt_from_EX;
            NB_DST_SEL'(REGDST_RD): dest = i_rd_from_EX;
            NB_DST_SEL'(REGDST_RA): dest = NB_REG'(REG_RA);
            default:                dest = '0;
        endcase
    end

    assign wr_ex = i_valid_ex & i_RegWrite_from_EX & (dest != '0) & ~mask;
    assign ld_ex = wr_ex & i_MemRead_from_EX;
    // Bubbles (invalid or masked) enter the slot with rd cleared.
    assign rd_ex = (i_valid_ex & ~mask) ? dest : '0;

`ifdef WRITEBACK_TRACKER_LOAD_USE_EN
    tracker_state_t state;
    tracker_state_t state_nxt;
    logic           hazard;

    assign mask   = (state == ST_LOAD_STALL);
    assign hazard = ld_ex & ((dest == i_rs_from_ID) | (dest == i_rt_from_ID));
    assign o_stall = i_rst_n & ~i_halt & (state == ST_RUN) & hazard;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:        if (o_stall) state_nxt = ST_LOAD_STALL;
            ST_LOAD_STALL: state_nxt = ST_RUN;
            default:       state_nxt = ST_RUN;
        endcase
    end

    // Halt holds the state so a pending bubble lands on the first free cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_RUN;
        end else if (!i_halt) begin
            state <= state_nxt;
        end
    end
`else
    logic unused_id;

    assign mask      = 1'b0;
    assign o_stall   = 1'b0;
    assign unused_id = ^{i_rs_from_ID, i_rt_from_ID};
`endif

    pipe_dest_slot #(.NB_REG(NB_REG)) u_slot_m (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_halt     (i_halt),
        .i_rd       (rd_ex),
        .i_RegWrite (wr_ex),
        .i_MemRead  (ld_ex),
        .o_rd       (o_rd_from_M),
        .o_RegWrite (o_RegWrite_from_M),
        .o_MemRead  (o_MemRead_from_M)
    );

    pipe_dest_slot #(.NB_REG(NB_REG)) u_slot_wb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_halt     (i_halt),
        .i_rd       (o_rd_from_M),
        .i_RegWrite (o_RegWrite_from_M),
        .i_MemRead  (o_MemRead_from_M),
        .o_rd       (o_rd_from_WB),
        .o_RegWrite (o_RegWrite_from_WB),
        .o_MemRead  (m_MemRead_unused_wb)
    );

endmodule

// File: tb/tb_writeback_tracker.sv
// tb/tb_writeback_tracker.sv - directed self-checking bench for writeback_tracker
module tb_writeback_tracker;

`ifdef WRITEBACK_TRACKER_LOAD_USE_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       halt;
    logic       valid_ex;
    logic [4:0] rt_ex;
    logic [4:0] rd_ex;
    logic [1:0] regdst;
    logic       regwrite;
    logic       memread;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] rd_m;
    logic       rw_m;
    logic       mr_m;
    logic [4:0] rd_wb;
    logic       rw_wb;
    logic       stall;

    int checks = 0;
    int errors = 0;

    writeback_tracker #(.NB_REG(5), .NB_DST_SEL(2)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_halt             (halt),
        .i_valid_ex         (valid_ex),
        .i_rt_from_EX       (rt_ex),
        .i_rd_from_EX       (rd_ex),
        .i_RegDst_from_EX   (regdst),
        .i_RegWrite_from_EX (regwrite),
        .i_MemRead_from_EX  (memread),
        .i_rs_from_ID       (rs_id),
        .i_rt_from_ID       (rt_id),
        .o_rd_from_M        (rd_m),
        .o_RegWrite_from_M  (rw_m),
        .o_MemRead_from_M   (mr_m),
        .o_rd_from_WB       (rd_wb),
        .o_RegWrite_from_WB (rw_wb),
        .o_stall            (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [1:0] dst, input logic [4:0] rt,
                          input logic [4:0] rd, input logic rw, input logic mr);
        valid_ex = v;
        regdst   = dst;
        rt_ex    = rt;
        rd_ex    = rd;
        regwrite = rw;
        memread  = mr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; rs_id = 5'd0; rt_id = 5'd0;
        set_ex(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_rd_m", rd_m, 5'd0);
        check("rst_rw_m", rw_m, 1'b0);
        check("rst_mr_m", mr_m, 1'b0);
        check("rst_rd_wb", rd_wb, 5'd0);
        check("rst_rw_wb", rw_wb, 1'b0);
        check("rst_stall", stall, 1'b0);
        rst_n = 1'b1;

        rs_id = 5'd5; rt_id = 5'd1;
        set_ex(1'b1, 2'b01, 5'd7, 5'd5, 1'b1, 1'b0);
        check("add_no_stall", stall, 1'b0);
        tick();
        check("add_rd_m", rd_m, 5'd5);
        check("add_rw_m", rw_m, 1'b1);
        check("add_mr_m", mr_m, 1'b0);
        set_ex(1'b1, 2'b10, 5'd3, 5'd2, 1'b1, 1'b0);
        tick();
        check("add_rd_wb", rd_wb, 5'd5);
        check("add_rw_wb", rw_wb, 1'b1);
        check("jal_rd_m", rd_m, 5'd31);
        check("jal_rw_m", rw_m, 1'b1);
        set_ex(1'b1, 2'b01, 5'd3, 5'd0, 1'b1, 1'b0);
        tick();
        check("r0_rw_m", rw_m, 1'b0);
        check("jal_rd_wb", rd_wb, 5'd31);
        set_ex(1'b1, 2'b11, 5'd9, 5'd9, 1'b1, 1'b0);
        tick();
        check("rsv_rw_m", rw_m, 1'b0);
        check("r0_rw_wb", rw_wb, 1'b0);
        rs_id = 5'd0; rt_id = 5'd0;
        set_ex(1'b1, 2'b00, 5'd0, 5'd3, 1'b1, 1'b1);
        check("lw_r0_stall", stall, 1'b0);
        tick();
        check("lw_r0_rw_m", rw_m, 1'b0);
        check("lw_r0_mr_m", mr_m, 1'b0);
        rs_id = 5'd1; rt_id = 5'd4;
        set_ex(1'b1, 2'b00, 5'd4, 5'd0, 1'b1, 1'b0);
        check("nonload_stall", stall, 1'b0);
        tick();
        rs_id = 5'd4; rt_id = 5'd4;
        set_ex(1'b1, 2'b00, 5'd4, 5'd0, 1'b1, 1'b1);
        check("lu_stall", stall, LU);
        tick();
        check("lu_rd_m", rd_m, 5'd4);
        check("lu_mr_m", mr_m, 1'b1);
        check("lu_rw_m", rw_m, 1'b1);
        set_ex(1'b1, 2'b01, 5'd0, 5'd6, 1'b1, 1'b0);
        check("lu_stall_once", stall, 1'b0);
        tick();
        check("bubble_rw_m", rw_m, !LU);
        check("bubble_rd_m", rd_m, (LU ? 5'd0 : 5'd6));
        check("lu_rd_wb", rd_wb, 5'd4);
        check("lu_rw_wb", rw_wb, 1'b1);
        rs_id = 5'd8; rt_id = 5'd2;
        set_ex(1'b1, 2'b00, 5'd8, 5'd0, 1'b1, 1'b1);
        check("lw8_stall", stall, LU);
        tick();
        check("lw8_rd_m", rd_m, 5'd8);
        halt = 1'b1;
        set_ex(1'b1, 2'b01, 5'd0, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("halt_stall", stall, 1'b0);
            tick();
            check("halt_rd_m", rd_m, 5'd8);
            check("halt_mr_m", mr_m, 1'b1);
            check("halt_rd_wb", rd_wb, (LU ? 5'd0 : 5'd6));
        end
        halt = 1'b0;
        #1;
        check("rel_stall", stall, 1'b0);
        tick();
        check("rel_rw_m", rw_m, !LU);
        check("rel_rd_m", rd_m, (LU ? 5'd0 : 5'd10));
        check("rel_rd_wb", rd_wb, 5'd8);
        rs_id = 5'd3; rt_id = 5'd12;
        set_ex(1'b1, 2'b00, 5'd12, 5'd0, 1'b1, 1'b1);
        check("run_stall", stall, LU);
        halt = 1'b1;
        #1;
        check("halt_forces_stall0", stall, 1'b0);
        halt = 1'b0;
        #1;
        check("run_stall_again", stall, LU);
        tick();
        check("lw12_rd_m", rd_m, 5'd12);
        check("lw12_mr_m", mr_m, 1'b1);
        rs_id = 5'd13; rt_id = 5'd0;
        set_ex(1'b1, 2'b00, 5'd13, 5'd0, 1'b1, 1'b1);
        tick();
        check("b2b_rw_m", rw_m, !LU);
        rs_id = 5'd14;
        set_ex(1'b1, 2'b00, 5'd14, 5'd0, 1'b1, 1'b1);
        rst_n = 1'b0; halt = 1'b1;
        #1;
        check("inrst_stall", stall, 1'b0);
        tick();
        check("mrst_rd_m", rd_m, 5'd0);
        check("mrst_rw_m", rw_m, 1'b0);
        check("mrst_mr_m", mr_m, 1'b0);
        check("mrst_rd_wb", rd_wb, 5'd0);
        check("mrst_rw_wb", rw_wb, 1'b0);
        rst_n = 1'b1; halt = 1'b0;
        #1;
        check("post_rst_stall", stall, LU);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_tracker.md
# writeback_tracker

Producer side of the EX-stage forwarding path: resolves each instruction's destination register in EX and carries it, with its write-enable and load flag, through the EX/M and M/WB slots. The registered outputs drive the forwarding unit's M- and WB-stage destination and RegWrite inputs. The block also detects load-use hazards against the instruction in ID and requests a one-cycle stall. It sits beside the ID/EX, EX/M and M/WB pipeline registers and is frozen by the debug unit's halt.

## Interface
Parameters:
- NB_REG, 5, register-index width
- NB_DST_SEL, 2, RegDst select width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- i_halt  in  1  debug freeze; holds all state
- i_valid_ex  in  1  EX holds a real instruction (0 = bubble)
- i_rt_from_EX  in  NB_REG  rt field of EX instruction
- i_rd_from_EX  in  NB_REG  rd field of EX instruction
- i_RegDst_from_EX  in  NB_DST_SEL  00 rt, 01 rd, 10 r31 (JAL), 11 reserved
- i_RegWrite_from_EX  in  1  EX instruction writes the register file
- i_MemRead_from_EX  in  1  EX instruction is a load
- i_rs_from_ID  in  NB_REG  ID source 1
- i_rt_from_ID  in  NB_REG  ID source 2
- o_rd_from_M  out  NB_REG  destination in M slot
- o_RegWrite_from_M  out  1  effective write-enable in M slot
- o_MemRead_from_M  out  1  M slot is a load
- o_rd_from_WB  out  NB_REG  destination in WB slot
- o_RegWrite_from_WB  out  1  effective write-enable in WB slot
- o_stall  out  1  load-use stall request to PC/IF-ID/ID-EX control

## Operation
- Destination select in EX:
  - RegDst 00 gives rt, 01 gives rd, 10 gives 5'd31.
  - RegDst 11 gives index 0 with write suppressed.
- Effective write: wr_ex = i_valid_ex & i_RegWrite_from_EX & (dest != 0) & ~mask. Writes to r0 never propagate.
- Effective load: ld_ex = wr_ex & i_MemRead_from_EX. A load targeting r0 is not a hazard.
- Each unhalted cycle, the EX slot moves into M and M moves into WB. Bubbles carry RegWrite=0, MemRead=0 and rd=0.
- FSM with two states, RUN and LOAD_STALL:
  - RUN: mask=0. o_stall = ld_ex & (dest == i_rs_from_ID | dest == i_rt_from_ID). When o_stall=1, go to LOAD_STALL. The load itself advances into M normally.
  - LOAD_STALL: mask=1, so the EX slot is captured as a bubble whatever i_valid_ex says, and o_stall=0. Return to RUN unconditionally.
- i_halt=1:
  - All slots and the FSM hold.
  - o_stall is forced to 0.
  - Registered outputs keep their values.
- Halt while in LOAD_STALL: the FSM stays in LOAD_STALL until the first unhalted cycle, and the bubble is inserted on that cycle.
- Reset (i_rst_n=0 at a clock edge) takes priority over halt:
  - Clears both slots (rd=0, RegWrite=0, MemRead=0) and sets FSM=RUN.
  - Every output is 0 during and after reset until a valid instruction arrives.
- i_rs_from_ID and i_rt_from_ID both matching the load destination: a single one-cycle stall.

## Timing
- Latency from EX inputs to o_*_from_M: 1 cycle. To o_*_from_WB: 2 cycles.
- o_stall is combinational from EX and ID inputs plus FSM state, valid in the same cycle. It asserts for exactly one cycle per hazard.
- The caller must hold the ID instruction and PC during the o_stall cycle. The next cycle's EX slot is a bubble by construction.
- Back-to-back loads each raise their own stall. A non-load in EX never stalls.
- No combinational path from any input to o_*_from_M or o_*_from_WB.

## Configuration
- WRITEBACK_TRACKER_LOAD_USE_EN defined: the FSM and o_stall logic are built as described above.
- WRITEBACK_TRACKER_LOAD_USE_EN undefined:
  - FSM removed, mask is 0, o_stall is tied to 0.
  - Slot propagation is unchanged.
  - Used with a software-scheduled (delay-slot-filled) toolchain.

## Structure
- Shared package mips_pkg holds:
  - NB_REG default
  - RegDst encodings (REGDST_RT, REGDST_RD, REGDST_RA, REGDST_RSV)
  - constant REG_RA = 31
  - the tracker FSM state type
- Sub-module pipe_dest_slot: one register slot {rd, RegWrite, MemRead} with hold (halt) and synchronous clear (reset). Instantiated twice, EX to M and M to WB.
- Top level holds the destination mux, effective-write logic and the FSM.

## Test plan
- Reset check: assert i_rst_n=0 mid-stream with non-zero slots -> all outputs 0 the next cycle, FSM=RUN.
- Propagation: EX ADD with RegDst=01, rd=5, RegWrite=1, valid=1 -> o_rd_from_M=5 and o_RegWrite_from_M=1 at cycle+1; o_rd_from_WB=5 and o_RegWrite_from_WB=1 at cycle+2.
- Special destinations:
  - JAL with RegDst=10 -> o_rd_from_M=31.
  - RegDst=01 with rd=0 -> o_RegWrite_from_M=0.
  - RegDst=11 -> o_RegWrite_from_M=0.
- Load-use: EX LW with RegDst=00, rt=4, MemRead=1; ID rs=4 -> o_stall=1 for one cycle. Next cycle o_rd_from_M=4 and o_MemRead_from_M=1. The cycle after, the M slot holds a bubble even with i_valid_ex=1.
- No false stall:
  - LW to r0 with ID rs=0 -> o_stall=0.
  - Non-load writing r4 with ID rt=4 -> o_stall=0.
- Halt: assert i_halt=1 for 3 cycles in LOAD_STALL -> outputs frozen and o_stall=0. On release, a bubble is inserted, then RUN resumes.
